// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: FSM encoding and default timing.

package stopwatch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } sw_state_e;

  localparam int unsigned DEFAULT_CLK_PER_MS = 2500;
  localparam int unsigned DEFAULT_CNT_W      = 16;

  // Lap capture is only meaningful while a measurement is in progress.
  function automatic logic lap_allowed(sw_state_e st);
    return (st == S_RUN) || (st == S_PAUSE);
  endfunction

endpackage

// File: rtl/ms_prescaler.sv
// Enabled, clearable divider producing a one-cycle tick every CLK_PER_MS enabled cycles.
// The phase is kept while disabled so a paused measurement resumes mid-millisecond.

module ms_prescaler
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_PER_MS = DEFAULT_CLK_PER_MS
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0] PreMax = PW'(CLK_PER_MS - 1);

  logic [PW-1:0] pre_q, pre_d;

  assign tick = en && (pre_q == PreMax);

  always_comb begin
    pre_d = pre_q;
    if (clr) begin
      pre_d = '0;
    end else if (tick) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/stop/clear/lap stopwatch built on a millisecond prescaler, with an optional alarm
// that freezes the count at the threshold. All outputs are registered.

module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_PER_MS = DEFAULT_CLK_PER_MS,
  parameter int unsigned CNT_W      = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             lap,
  input  logic             alarm_en,
  input  logic [CNT_W-1:0] alarm_val,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] lap_val,
  output logic             lap_valid,
  output logic             running,
  output logic             alarm,
  output logic             ovf,
  output logic [1:0]       state
);

  sw_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] lap_val_q, lap_val_d;
  logic             lap_valid_q, lap_valid_d;
  logic             alarm_q, alarm_d;
  logic             ovf_q, ovf_d;
  logic             running_q, running_d;

  logic             tick;
  logic             presc_en;
  logic [CNT_W-1:0] count_inc;
  logic             wrap;
  logic             hit;
  logic             lap_take;

  // stop and clear both suppress a tick landing in the same cycle.
  assign presc_en = (state_q == S_RUN) && !stop && !clear;

  ms_prescaler #(
    .CLK_PER_MS(CLK_PER_MS)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (presc_en),
    .clr (clear),
    .tick(tick)
  );

  assign count_inc = count_q + CNT_W'(1);
  assign wrap      = (count_q == '1);
  assign hit       = alarm_en && tick && (count_inc == alarm_val);
  // Lap is the lowest-priority command; any other command in the same cycle wins.
  assign lap_take  = lap && !clear && !stop && !start && lap_allowed(state_q);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    lap_val_d   = lap_val_q;
    lap_valid_d = 1'b0;
    alarm_d     = 1'b0;
    ovf_d       = 1'b0;

    if (clear) begin
      state_d   = S_IDLE;
      count_d   = '0;
      lap_val_d = '0;
    end else begin
      if (lap_take) begin
        lap_val_d   = count_q;
        lap_valid_d = 1'b1;
      end
      if (tick) begin
        count_d = count_inc;
        ovf_d   = wrap;
      end
      unique case (state_q)
        S_IDLE: begin
          if (!stop && start) state_d = S_RUN;
        end
        S_RUN: begin
          if (stop) begin
            state_d = S_PAUSE;
          end else if (hit) begin
            state_d = S_DONE;
            alarm_d = 1'b1;
          end
        end
        S_PAUSE: begin
          if (!stop && start) state_d = S_RUN;
        end
        S_DONE: begin
          state_d = S_DONE;
        end
      endcase
    end

    running_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      lap_val_q   <= '0;
      lap_valid_q <= 1'b0;
      alarm_q     <= 1'b0;
      ovf_q       <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      lap_val_q   <= lap_val_d;
      lap_valid_q <= lap_valid_d;
      alarm_q     <= alarm_d;
      ovf_q       <= ovf_d;
      running_q   <= running_d;
    end
  end

  assign count     = count_q;
  assign lap_val   = lap_val_q;
  assign lap_valid = lap_valid_q;
  assign running   = running_q;
  assign alarm     = alarm_q;
  assign ovf       = ovf_q;
  assign state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: a 16-bit and a 4-bit instance share stimulus and are both
// checked every cycle against a behavioural model, plus hand-computed spot checks.

module tb_stopwatch_ctrl;

  localparam int unsigned P = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0, alarm_en = 1'b0;
  logic [15:0] alarm_val = '0;

  logic [15:0] cnt16, lapv16;
  logic        lapok16, run16, alm16, ovf16;
  logic [1:0]  st16;
  logic [3:0]  cnt4, lapv4;
  logic        lapok4, run4, alm4, ovf4;
  logic [1:0]  st4;

  stopwatch_ctrl #(.CLK_PER_MS(P), .CNT_W(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .alarm_en(alarm_en), .alarm_val(alarm_val),
    .count(cnt16), .lap_val(lapv16), .lap_valid(lapok16), .running(run16),
    .alarm(alm16), .ovf(ovf16), .state(st16)
  );

  stopwatch_ctrl #(.CLK_PER_MS(P), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .alarm_en(alarm_en), .alarm_val(alarm_val[3:0]),
    .count(cnt4), .lap_val(lapv4), .lap_valid(lapok4), .running(run4),
    .alarm(alm4), .ovf(ovf4), .state(st4)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  // Model state per instance: 0 = 16-bit, 1 = 4-bit. States: 0 idle, 1 run, 2 pause, 3 done.
  int m_st[2], m_pre[2], m_cnt[2], m_lap[2], m_lapv[2], m_alm[2], m_ovf[2];
  int modv[2] = '{65536, 16};

  always @(posedge clk) begin : model
    int st, pre, cnt, lp, lv, al, ov, nc;
    bit tk;
    for (int i = 0; i < 2; i++) begin
      st = m_st[i]; pre = m_pre[i]; cnt = m_cnt[i]; lp = m_lap[i];
      lv = 0; al = 0; ov = 0;
      if (rst || clear) begin
        st = 0; pre = 0; cnt = 0; lp = 0;
      end else begin
        tk = (st == 1) && !stop && (pre == P - 1);
        if (lap && !stop && !start && (st == 1 || st == 2)) begin
          lp = cnt;
          lv = 1;
        end
        if (tk) begin
          pre = 0;
          nc  = (cnt + 1) % modv[i];
          ov  = (nc == 0) ? 1 : 0;
          cnt = nc;
          if (alarm_en && nc == int'(alarm_val) % modv[i]) begin
            al = 1;
            st = 3;
          end
        end else if (st == 1 && !stop) begin
          pre = pre + 1;
        end
        if (st != 3) begin
          if (stop) begin
            if (st == 1) st = 2;
          end else if (start && (st == 0 || st == 2)) begin
            st = 1;
          end
        end
      end
      m_st[i] <= st; m_pre[i] <= pre; m_cnt[i] <= cnt; m_lap[i] <= lp;
      m_lapv[i] <= lv; m_alm[i] <= al; m_ovf[i] <= ov;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input int i, input logic [31:0] c, input logic [31:0] lv,
                     input logic [31:0] lk, input logic [31:0] r, input logic [31:0] a,
                     input logic [31:0] o, input logic [31:0] s);
    chk($sformatf("m%0d.count", i), c, m_cnt[i]);
    chk($sformatf("m%0d.lap_val", i), lv, m_lap[i]);
    chk($sformatf("m%0d.lap_valid", i), lk, m_lapv[i]);
    chk($sformatf("m%0d.running", i), r, (m_st[i] == 1) ? 1 : 0);
    chk($sformatf("m%0d.alarm", i), a, m_alm[i]);
    chk($sformatf("m%0d.ovf", i), o, m_ovf[i]);
    chk($sformatf("m%0d.state", i), s, m_st[i]);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp(0, cnt16, lapv16, lapok16, run16, alm16, ovf16, st16);
      cmp(1, cnt4, lapv4, lapok4, run4, alm4, ovf4, st4);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1; step(1); clear = 1'b0;
  endtask

  initial begin
    // Reset
    step(3);
    cmp_en = 1'b1;
    chk("rst.count", cnt16, 0);
    chk("rst.state", st16, 0);
    chk("rst.running", run16, 0);
    chk("rst.lap_valid", lapok16, 0);
    rst = 1'b0;
    step(1);

    // Free run 40 cycles
    start = 1'b1; step(1); start = 1'b0;
    step(40);
    chk("run40.count16", cnt16, 10);
    chk("run40.count4", cnt4, 10);
    chk("run40.running", run16, 1);
    chk("run40.alarm", alm16, 0);
    chk("run40.ovf", ovf16, 0);
    do_clear();
    chk("clr.count", cnt16, 0);
    chk("clr.state", st16, 0);

    // Pause holds partial millisecond
    start = 1'b1; step(1); start = 1'b0;
    step(6);
    stop = 1'b1; step(1); stop = 1'b0;
    chk("pause.state", st16, 2);
    chk("pause.count", cnt16, 1);
    step(20);
    chk("pause.hold", cnt16, 1);
    start = 1'b1; step(1); start = 1'b0;
    step(1);
    chk("resume1.count", cnt16, 1);
    step(1);
    chk("resume2.count", cnt16, 2);
    do_clear();

    // Stop during a tick cycle
    start = 1'b1; step(1); start = 1'b0;
    step(3);
    stop = 1'b1; step(1); stop = 1'b0;
    chk("stoptick.count", cnt16, 0);
    chk("stoptick.state", st16, 2);
    start = 1'b1; step(1); start = 1'b0;
    step(1);
    chk("stoptick.resume", cnt16, 1);
    do_clear();

    // Alarm at 5 ms
    alarm_en = 1'b1; alarm_val = 16'd5;
    start = 1'b1; step(1); start = 1'b0;
    step(19);
    chk("alm.pre.alarm", alm16, 0);
    chk("alm.pre.count", cnt16, 4);
    step(1);
    chk("alm.hit.alarm16", alm16, 1);
    chk("alm.hit.alarm4", alm4, 1);
    chk("alm.hit.count", cnt16, 5);
    chk("alm.hit.state", st16, 3);
    step(1);
    chk("alm.post.alarm", alm16, 0);
    start = 1'b1; step(1); start = 1'b0;
    lap = 1'b1; step(1); lap = 1'b0;
    chk("done.lap_valid", lapok16, 0);
    chk("done.state", st16, 3);
    step(8);
    chk("done.count", cnt16, 5);
    do_clear();
    chk("done.clr.state", st16, 0);
    chk("done.clr.count", cnt16, 0);
    alarm_en = 1'b0;

    // 4-bit wrap after 64 cycles
    start = 1'b1; step(1); start = 1'b0;
    step(63);
    chk("wrap.pre.count4", cnt4, 15);
    chk("wrap.pre.ovf4", ovf4, 0);
    step(1);
    chk("wrap.count4", cnt4, 0);
    chk("wrap.ovf4", ovf4, 1);
    chk("wrap.count16", cnt16, 16);
    chk("wrap.ovf16", ovf16, 0);
    step(1);
    chk("wrap.post.ovf4", ovf4, 0);
    do_clear();

    // alarm_val = 0 only hits on wrap
    alarm_en = 1'b1; alarm_val = 16'd0;
    start = 1'b1; step(1); start = 1'b0;
    step(64);
    chk("alm0.ovf4", ovf4, 1);
    chk("alm0.alarm4", alm4, 1);
    chk("alm0.state4", st4, 3);
    chk("alm0.state16", st16, 1);
    chk("alm0.alarm16", alm16, 0);
    step(4);
    chk("alm0.hold4", cnt4, 0);
    do_clear();
    alarm_en = 1'b0;

    // Lap on the tick cycle
    start = 1'b1; step(1); start = 1'b0;
    step(31);
    chk("lap.pre.count", cnt16, 7);
    lap = 1'b1; step(1); lap = 1'b0;
    chk("lap.val16", lapv16, 7);
    chk("lap.val4", lapv4, 7);
    chk("lap.valid", lapok16, 1);
    chk("lap.count", cnt16, 8);
    step(1);
    chk("lap.post.valid", lapok16, 0);

    // clear + lap in RUN
    clear = 1'b1; lap = 1'b1; step(1); clear = 1'b0; lap = 1'b0;
    chk("clrlap.state", st16, 0);
    chk("clrlap.lap_val", lapv16, 0);
    chk("clrlap.valid", lapok16, 0);

    // start + stop from IDLE
    start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
    chk("ss.state", st16, 0);
    chk("ss.running", run16, 0);
    step(5);
    chk("ss.count", cnt16, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
